// File: rtl/wb_exc_ctrl.sv
// Write-back stage exception controller: retires one entry per cycle, reports
// exceptions/ERTN to the CSR file, and holds a fetch redirect until accepted.
module wb_exc_ctrl #(
  parameter int          WB2CSR_LEN = 81,
  parameter logic [5:0]  ECODE_INT  = 6'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic [31:0]           ms_pc,
  input  logic                  ms_ex,
  input  logic [5:0]            ms_ecode,
  input  logic [8:0]            ms_esubcode,
  input  logic [31:0]           ms_vaddr,
  input  logic                  ms_ertn,
  input  logic [79:0]           ms_csr_ctrl,
  input  logic                  ms_rf_we,
  input  logic [4:0]            ms_rf_waddr,
  input  logic [31:0]           ms_rf_wdata,
  input  logic                  ms_res_from_csr,
  input  logic                  has_int,
  input  logic [31:0]           ex_entry,
  input  logic [31:0]           era_pc,
  input  logic [31:0]           csr_rvalue,
  output logic [79:0]           csr_ctrl,
  output logic                  csr_valid,
  output logic [WB2CSR_LEN-1:0] csr_in_bus,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ready
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t state, state_next;

  logic        ws_valid;
  logic [31:0] pc_q;
  logic        ex_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esubcode_q;
  logic [31:0] vaddr_q;
  logic        ertn_q;
  logic        rf_we_q;
  logic [31:0] rf_wdata_q;
  logic        res_from_csr_q;

  logic        commit;
  logic        int_take;
  logic        ex_any;
  logic        ertn_flush;
  logic        load;
  logic [5:0]  rep_ecode;
  logic [8:0]  rep_esubcode;
  logic [80:0] report;

  assign ws_allowin = (state == RUN);
  assign commit     = ws_valid && (state == RUN);
  assign int_take   = commit && has_int;
  assign ex_any     = int_take || (commit && ex_q);
  assign ertn_flush = commit && ertn_q && !ex_any;
  assign flush      = commit && (ex_any || ertn_flush);
  // The flush cycle must not accept the younger instruction sitting in MEM.
  assign load       = ms_to_ws_valid && ws_allowin && !flush;

  assign rep_ecode    = int_take ? ECODE_INT : ecode_q;
  assign rep_esubcode = int_take ? 9'd0      : esubcode_q;
  assign report       = {ertn_flush, ex_any, rep_ecode, rep_esubcode, pc_q, vaddr_q};
  assign csr_in_bus   = WB2CSR_LEN'(report);

  assign csr_valid = commit && !ex_any;
  assign rf_we     = commit && rf_we_q && !ex_any;
  assign rf_wdata  = res_from_csr_q ? csr_rvalue : rf_wdata_q;

  assign redirect_valid = (state == REDIR);

  // NOTE: next-state logic assigns its default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:   if (flush)          state_next = REDIR;
      REDIR: if (redirect_ready) state_next = RUN;
      default:                   state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      ws_valid    <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      state <= state_next;
      if (load)
        ws_valid <= 1'b1;
      else if (commit)
        ws_valid <= 1'b0;
      if (flush)
        redirect_pc <= ex_any ? ex_entry : era_pc;
    end
  end

  // NOTE: entry payload is qualified by ws_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      pc_q           <= ms_pc;
      ex_q           <= ms_ex;
      ecode_q        <= ms_ecode;
      esubcode_q     <= ms_esubcode;
      vaddr_q        <= ms_vaddr;
      ertn_q         <= ms_ertn;
      csr_ctrl       <= ms_csr_ctrl;
      rf_we_q        <= ms_rf_we;
      rf_waddr       <= ms_rf_waddr;
      rf_wdata_q     <= ms_rf_wdata;
      res_from_csr_q <= ms_res_from_csr;
    end
  end

endmodule
